// File: rtl/spi_txn_arbiter_if.sv
// Bundled requester, response, config and SPI-master signals of the transaction arbiter.
// The slave view belongs to the arbiter; the master view drives it.
interface spi_txn_arbiter_if #(
    parameter int NUM_REQ       = 4,
    parameter int CLK_DIV_WIDTH = 8
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [8*NUM_REQ-1:0]     req_data;
    logic [NUM_REQ-1:0]       req_lock;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [7:0]               rsp_data;
    logic [2:0]               rsp_id;
    logic                     rsp_err;
    logic                     cfg_we;
    logic [2:0]               cfg_idx;
    logic [1:0]               cfg_mode;
    logic [CLK_DIV_WIDTH-1:0] cfg_div;
    logic [1:0]               cfg_cs;
    logic                     m_start;
    logic [7:0]               m_data_tx;
    logic [1:0]               m_cpol_cpha;
    logic [CLK_DIV_WIDTH-1:0] m_clk_div;
    logic [1:0]               m_cs_select;
    logic                     m_busy;
    logic                     m_done;
    logic [7:0]               m_data_rx;

    modport slave (
        input  req_valid, req_data, req_lock, rsp_ready,
        input  cfg_we, cfg_idx, cfg_mode, cfg_div, cfg_cs,
        input  m_busy, m_done, m_data_rx,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err,
        output m_start, m_data_tx, m_cpol_cpha, m_clk_div, m_cs_select
    );

    modport master (
        output req_valid, req_data, req_lock, rsp_ready,
        output cfg_we, cfg_idx, cfg_mode, cfg_div, cfg_cs,
        output m_busy, m_done, m_data_rx,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err,
        input  m_start, m_data_tx, m_cpol_cpha, m_clk_div, m_cs_select
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter serialising per-requester SPI byte transactions onto one SPI master,
// with per-requester mode/divider/chip-select, locked bursts and a completion timeout.
module spi_txn_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int CLK_DIV_WIDTH = 8,
    parameter int TIMEOUT       = 4096
) (
    input logic              clk,
    input logic              reset,
    spi_txn_arbiter_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RESP, ERR} state_t;
    state_t state_reg, state_next;

    logic [TW-1:0]            timer_reg;
    logic [2:0]               last_grant_reg, winner_reg;
    logic [NUM_REQ-1:0]       win_onehot_reg;
    logic [7:0]               tx_reg, rx_reg;
    logic [1:0]               m_mode_reg, m_cs_reg;
    logic [CLK_DIV_WIDTH-1:0] m_div_reg;

    logic [NUM_REQ-1:0] upper_mask, upper_req, pick_vec, pick_onehot, sel_onehot;
    logic [NUM_REQ-1:0] req_ready_next;
    logic               grant_new, grant_cont, m_start_next, lock_hit, handshake;

    logic [2:0]               idx_chain  [NUM_REQ+1];
    logic [7:0]               data_chain [NUM_REQ+1];
    logic [1:0]               mode_chain [NUM_REQ+1];
    logic [1:0]               cs_chain   [NUM_REQ+1];
    logic [CLK_DIV_WIDTH-1:0] div_chain  [NUM_REQ+1];

    assign idx_chain[0]  = '0;
    assign data_chain[0] = '0;
    assign mode_chain[0] = '0;
    assign cs_chain[0]   = '0;
    assign div_chain[0]  = '0;

    // Requesters above last_grant take priority; otherwise wrap to the lowest valid one.
    assign upper_req   = bus.req_valid & upper_mask;
    assign pick_vec    = (|upper_req) ? upper_req : bus.req_valid;
    assign pick_onehot = pick_vec & (-pick_vec);
    assign sel_onehot  = (state_reg == IDLE) ? pick_onehot : win_onehot_reg;
    assign lock_hit    = |(win_onehot_reg & bus.req_lock & bus.req_valid);
    assign handshake   = bus.rsp_valid && bus.rsp_ready;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [1:0]               mode_reg;
            logic [CLK_DIV_WIDTH-1:0] div_reg;
            logic [1:0]               cs_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mode_reg <= 2'b00;
                    div_reg  <= CLK_DIV_WIDTH'(2);
                    cs_reg   <= 2'(gi % 4);
                end else if (bus.cfg_we && bus.cfg_idx == 3'(gi)) begin
                    mode_reg <= bus.cfg_mode;
                    div_reg  <= bus.cfg_div;
                    cs_reg   <= bus.cfg_cs;
                end
            end

            assign upper_mask[gi]   = (3'(gi) > last_grant_reg);
            assign idx_chain[gi+1]  = idx_chain[gi]  | (sel_onehot[gi] ? 3'(gi) : 3'd0);
            assign data_chain[gi+1] = data_chain[gi] | (sel_onehot[gi] ? bus.req_data[8*gi +: 8] : 8'h00);
            assign mode_chain[gi+1] = mode_chain[gi] | (sel_onehot[gi] ? mode_reg : 2'b00);
            assign cs_chain[gi+1]   = cs_chain[gi]   | (sel_onehot[gi] ? cs_reg : 2'b00);
            assign div_chain[gi+1]  = div_chain[gi]  | (sel_onehot[gi] ? div_reg : '0);
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        req_ready_next = '0;
        grant_new      = 1'b0;
        grant_cont     = 1'b0;
        m_start_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|bus.req_valid) begin
                    req_ready_next = pick_onehot;
                    grant_new      = 1'b1;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.m_busy) begin
                    m_start_next = 1'b1;
                    state_next   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.m_done)
                    state_next = RESP;
                else if (timer_reg == TW'(TIMEOUT - 2))
                    state_next = ERR;
            end
            RESP, ERR: begin
                if (bus.rsp_ready) begin
                    // A locked requester keeps chip-select: reissue without re-arbitrating.
                    if (state_reg == RESP && lock_hit) begin
                        req_ready_next = win_onehot_reg;
                        grant_cont     = 1'b1;
                        state_next     = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            last_grant_reg <= 3'(NUM_REQ - 1);
            winner_reg     <= '0;
            win_onehot_reg <= '0;
            tx_reg         <= '0;
            rx_reg         <= '0;
            m_mode_reg     <= 2'b00;
            m_div_reg      <= CLK_DIV_WIDTH'(2);
            m_cs_reg       <= 2'b00;
        end else begin
            state_reg <= state_next;
            timer_reg <= (state_reg == WAIT_DONE) ? timer_reg + 1'b1 : '0;
            if (grant_new) begin
                winner_reg     <= idx_chain[NUM_REQ];
                win_onehot_reg <= pick_onehot;
                m_mode_reg     <= mode_chain[NUM_REQ];
                m_div_reg      <= div_chain[NUM_REQ];
                m_cs_reg       <= cs_chain[NUM_REQ];
            end
            if (grant_new || grant_cont)
                tx_reg <= data_chain[NUM_REQ];
            if (state_reg == WAIT_DONE && bus.m_done)
                rx_reg <= bus.m_data_rx;
            if (handshake)
                last_grant_reg <= winner_reg;
        end
    end

    assign bus.req_ready   = reset ? '0 : req_ready_next;
    assign bus.m_start     = m_start_next;
    assign bus.rsp_valid   = (state_reg == RESP) || (state_reg == ERR);
    assign bus.rsp_err     = (state_reg == ERR);
    assign bus.rsp_data    = (state_reg == ERR) ? 8'h00 : rx_reg;
    assign bus.rsp_id      = winner_reg;
    assign bus.m_data_tx   = tx_reg;
    assign bus.m_cpol_cpha = m_mode_reg;
    assign bus.m_clk_div   = m_div_reg;
    assign bus.m_cs_select = m_cs_reg;
endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter CLK_DIV_WIDTH, default 8, width of the SPI divider.
REQ-003 SHALL have parameter TIMEOUT, default 4096, cycles allowed from m_start to m_done.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  NUM_REQ  per-requester byte request.
REQ-007 SHALL have port req_data  in  8*NUM_REQ  TX byte, requester i at [8i+7:8i].
REQ-008 SHALL have port req_lock  in  NUM_REQ  hold grant for the next byte (burst, CS held).
REQ-009 SHALL have port req_ready  out  NUM_REQ  one-hot accept pulse.
REQ-010 SHALL have port rsp_valid / rsp_ready  out / in  1  response handshake.
REQ-011 SHALL have port rsp_data  out  8  RX byte; rsp_id  out  3  requester index; rsp_err  out  1  timeout flag.
REQ-012 SHALL have port cfg_we  in  1; cfg_idx  in  3; cfg_mode  in  2 {CPOL,CPHA}; cfg_div  in  CLK_DIV_WIDTH; cfg_cs  in  2: per-requester config write.
REQ-013 SHALL have port m_start  out  1; m_data_tx  out  8; m_cpol_cpha  out  2; m_clk_div  out  CLK_DIV_WIDTH; m_cs_select  out  2: drive the SPI master.
REQ-014 SHALL have port m_busy  in  1; m_done  in  1; m_data_rx  in  8: SPI master status.

Function
REQ-015 SHALL hold per-requester config registers {mode, div, cs}; cfg_we writes entry cfg_idx; cfg_idx >= NUM_REQ ignored.
REQ-016 SHALL implement states IDLE, ISSUE, WAIT_DONE, RESP, ERR.
REQ-017 IDLE: any req_valid -> select winner round-robin starting at (last_grant+1) mod NUM_REQ; pulse req_ready[winner] that cycle; latch req_data, config of winner; -> ISSUE.
REQ-018 ISSUE: when m_busy==0 assert m_start for exactly one cycle, clear timer, -> WAIT_DONE; while m_busy==1 wait with m_start=0.
REQ-019 m_data_tx, m_cpol_cpha, m_clk_div, m_cs_select SHALL be registered, stable from ISSUE entry until RESP exit.
REQ-020 WAIT_DONE: timer increments per cycle; m_done==1 -> latch m_data_rx, -> RESP; timer reaching TIMEOUT-1 without m_done -> ERR; m_done wins if both same cycle.
REQ-021 RESP: rsp_valid=1, rsp_err=0, rsp_data/rsp_id held until rsp_ready; on handshake last_grant <= winner.
REQ-022 ERR: rsp_valid=1, rsp_err=1, rsp_data=8'h00; same handshake as RESP.
REQ-023 On RESP/ERR handshake: if req_lock[winner] && req_valid[winner] && !rsp_err, pulse req_ready[winner], latch new byte, -> ISSUE (no arbitration); else -> IDLE.
REQ-024 req_ready SHALL be at most one-hot and only asserted in the cycle a byte is latched.
REQ-025 A config write to the granted requester SHALL take effect on its next IDLE grant, not mid-burst.
REQ-026 m_done outside WAIT_DONE SHALL be ignored.
REQ-027 Round-robin SHALL guarantee each valid requester a grant within NUM_REQ completed non-locked transactions.

Reset
REQ-028 Reset SHALL force IDLE immediately, mid-operation included; req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, rsp_id=0, m_start=0, m_data_tx=0.
REQ-029 Reset SHALL set all config entries to mode=2'b00, div=2, cs=index mod 4; m_* config outputs to entry 0 values; last_grant=NUM_REQ-1 (requester 0 first).

Verification
REQ-030 Single: req_valid[1]=1, data 8'hA5, master returns 8'h3C -> one m_start pulse, rsp_id=1, rsp_data=8'h3C, rsp_err=0.
REQ-031 Contention: req_valid=4'b1111 held, no lock -> grant order 0,1,2,3,0; exactly one req_ready per transaction.
REQ-032 Burst: requester 2 lock=1 for 3 bytes while req_valid[0]=1 -> three consecutive rsp_id=2, then rsp_id=0.
REQ-033 Timeout: TIMEOUT=16, m_done never asserted -> rsp_err=1, rsp_data=8'h00 exactly 16 cycles after m_start; next request serviced normally.
REQ-034 Config: write idx 3 mode=2'b11, div=8'd10, cs=2 -> requester 3 transaction shows m_cpol_cpha=2'b11, m_clk_div=10, m_cs_select=2; m_busy held 1 delays m_start.
REQ-035 Reset mid-WAIT_DONE -> all outputs at reset values same cycle; later m_done produces no response.
